// File: rtl/rv_mem_pkg.sv
// Shared definitions for the memory stage: access-size codes, atomic op
// codes and the bus handshake FSM encoding.
package rv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] AMO_NONE = 2'b00;
    localparam logic [1:0] AMO_LR   = 2'b01;
    localparam logic [1:0] AMO_SC   = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero
// extension for loads. Purely combinational.
module load_store_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Pick the addressed byte and half-word out of the bus word
    always_comb begin
        rd_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
        rd_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Size decode: store replication/strobes, load extension, alignment check
    always_comb begin
        wdata_o     = store_data_i;
        wstrb_o     = 4'b1111;
        load_data_o = rdata_i;
        misalign_o  = 1'b0;
        case (funct3_i)
            F3_LB, F3_LBU: begin
                wdata_o     = {4{store_data_i[7:0]}};
                wstrb_o     = 4'b0001 << addr_lo_i;
                load_data_o = (funct3_i == F3_LB) ? {{24{rd_byte[7]}}, rd_byte}
                                                  : {24'h0, rd_byte};
            end
            F3_LH, F3_LHU: begin
                wdata_o     = {2{store_data_i[15:0]}};
                wstrb_o     = 4'b0011 << addr_lo_i;
                load_data_o = (funct3_i == F3_LH) ? {{16{rd_half[15]}}, rd_half}
                                                  : {16'h0, rd_half};
                misalign_o  = addr_lo_i[0];
            end
            F3_LW: begin
                misalign_o = (addr_lo_i != 2'b00);
            end
            default: begin
                misalign_o = (addr_lo_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MEM stage with the MEM/WB register. Drives the data bus through a
// req/ack handshake with timeout, holds the LR/SC reservation and
// registers results into the W stage.
//
// state   | meaning
// IDLE    | no outstanding bus request (or zero-wait completion)
// WAIT    | request issued, waiting for dmem_ack; cnt_q counts wait cycles
module memory_stage
    import rv_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int XLEN           = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ValidM,
    input  logic            RegWriteM,
    input  logic            ResultSrcM,
    input  logic            isFPUM,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic [1:0]      AmoOpM,
    input  logic [2:0]      Funct3M,
    input  logic [4:0]      RdM,
    input  logic [XLEN-1:0] ALU_ResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [XLEN-1:0] FP_WriteDataM,
    input  logic [XLEN-1:0] FP_ALU_ResultM,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            StallM,
    output logic            ValidW,
    output logic            RegWriteW,
    output logic            ResultSrcW,
    output logic            isFPUW,
    output logic [4:0]      RdW,
    output logic [XLEN-1:0] ALU_ResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [XLEN-1:0] FP_ALU_ResultW,
    output logic [XLEN-1:0] FP_ReadDataW,
    output logic            MisalignW,
    output logic            BusErrW
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT_CYCLES);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resv_valid_q, resv_valid_d;
    logic [29:0]      resv_addr_q, resv_addr_d;

    logic        mem_op, sc_op, lr_op;
    logic        misalign_raw, misalign, sc_fail;
    logic        req, timeout_hit, stall, resv_hit;
    logic [31:0] store_src, al_wdata, al_load;
    logic [3:0]  al_wstrb;

    assign mem_op    = ValidM & (MemReadM | MemWriteM);
    assign sc_op     = mem_op & (AmoOpM == AMO_SC);
    assign lr_op     = mem_op & (AmoOpM == AMO_LR);
    assign store_src = isFPUM ? FP_WriteDataM : WriteDataM;
    assign resv_hit  = resv_valid_q & (resv_addr_q == ALU_ResultM[31:2]);
    assign misalign  = mem_op & misalign_raw;
    assign sc_fail   = sc_op & ~resv_hit;

    load_store_align u_align (
        .funct3_i     (Funct3M),
        .addr_lo_i    (ALU_ResultM[1:0]),
        .store_data_i (store_src),
        .rdata_i      (dmem_rdata),
        .wdata_o      (al_wdata),
        .wstrb_o      (al_wstrb),
        .load_data_o  (al_load),
        .misalign_o   (misalign_raw)
    );

    // Gating with rst_n makes the request vanish the moment reset asserts
    assign req         = rst_n & mem_op & ~misalign & ~sc_fail;
    assign timeout_hit = req & (state_q == ST_WAIT) & ~dmem_ack & (cnt_q == CNT_TMO);
    assign stall       = req & ~dmem_ack & ~timeout_hit;

    assign dmem_req   = req;
    assign dmem_we    = rst_n & MemWriteM;
    assign dmem_addr  = rst_n ? {ALU_ResultM[31:2], 2'b00} : '0;
    assign dmem_wdata = rst_n ? al_wdata : '0;
    assign dmem_wstrb = (req & MemWriteM) ? al_wstrb : 4'b0000;
    assign StallM     = stall;

    // Handshake FSM state and wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake FSM next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req & ~dmem_ack) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (dmem_ack | timeout_hit | ~req) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reservation update on completing instructions; an LR set wins last
    always_comb begin
        resv_valid_d = resv_valid_q;
        resv_addr_d  = resv_addr_q;
        if (mem_op & ~stall) begin
            if (sc_op) begin
                resv_valid_d = 1'b0;
            end else if (req & MemWriteM & dmem_ack & resv_hit) begin
                resv_valid_d = 1'b0;
            end
            if (lr_op & MemReadM & req & dmem_ack) begin
                resv_valid_d = 1'b1;
                resv_addr_d  = ALU_ResultM[31:2];
            end
        end
    end

    // Reservation registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
        end else begin
            resv_valid_q <= resv_valid_d;
            resv_addr_q  <= resv_addr_d;
        end
    end

    // MEM/WB register: bubble while stalled, otherwise capture the M stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ValidW         <= 1'b0;
            RegWriteW      <= 1'b0;
            ResultSrcW     <= 1'b0;
            isFPUW         <= 1'b0;
            RdW            <= '0;
            ALU_ResultW    <= '0;
            ReadDataW      <= '0;
            FP_ALU_ResultW <= '0;
            FP_ReadDataW   <= '0;
            MisalignW      <= 1'b0;
            BusErrW        <= 1'b0;
        end else if (stall) begin
            ValidW    <= 1'b0;
            RegWriteW <= 1'b0;
            MisalignW <= 1'b0;
            BusErrW   <= 1'b0;
        end else begin
            ValidW         <= ValidM;
            RegWriteW      <= RegWriteM & ValidM & ~misalign & ~timeout_hit;
            ResultSrcW     <= sc_op ? 1'b0 : ResultSrcM;
            isFPUW         <= isFPUM;
            RdW            <= RdM;
            ALU_ResultW    <= sc_op ? {31'h0, sc_fail} : ALU_ResultM;
            ReadDataW      <= al_load;
            FP_ALU_ResultW <= FP_ALU_ResultM;
            FP_ReadDataW   <= (isFPUM & MemReadM) ? dmem_rdata : '0;
            MisalignW      <= misalign;
            BusErrW        <= timeout_hit;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: single-cycle vector table plus
// hand-written stall, timeout, LR/SC and reset sequences.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ValidM, RegWriteM, ResultSrcM, isFPUM, MemReadM, MemWriteM;
    logic [1:0]  AmoOpM;
    logic [2:0]  Funct3M;
    logic [4:0]  RdM;
    logic [31:0] ALU_ResultM, WriteDataM, FP_WriteDataM, FP_ALU_ResultM;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        StallM, ValidW, RegWriteW, ResultSrcW, isFPUW, MisalignW, BusErrW;
    logic [4:0]  RdW;
    logic [31:0] ALU_ResultW, ReadDataW, FP_ALU_ResultW, FP_ReadDataW;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memory_stage #(.TIMEOUT_CYCLES(16), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .isFPUM(isFPUM),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .AmoOpM(AmoOpM), .Funct3M(Funct3M),
        .RdM(RdM), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
        .FP_WriteDataM(FP_WriteDataM), .FP_ALU_ResultM(FP_ALU_ResultM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .StallM(StallM),
        .ValidW(ValidW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .isFPUW(isFPUW),
        .RdW(RdW), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
        .FP_ALU_ResultW(FP_ALU_ResultW), .FP_ReadDataW(FP_ReadDataW),
        .MisalignW(MisalignW), .BusErrW(BusErrW)
    );

    // ctl = {valid, regwrite, resultsrc, isfpu, memread, memwrite}; e_rwrs = {RegWriteW, ResultSrcW}
    typedef struct {
        logic [5:0]  ctl;
        logic [1:0]  amo;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] fpwd;
        logic [31:0] rdata;
        logic        ack;
        logic        e_req;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
        logic [1:0]  e_rwrs;
        logic [31:0] e_rdw;
        logic [31:0] e_fprd;
        logic        e_mis;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [5:0] ctl, input logic [1:0] amo, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] fpwd,
                          input logic [31:0] rdata, input logic ack, input logic [4:0] rd);
        ValidM         = ctl[5];
        RegWriteM      = ctl[4];
        ResultSrcM     = ctl[3];
        isFPUM         = ctl[2];
        MemReadM       = ctl[1];
        MemWriteM      = ctl[0];
        AmoOpM         = amo;
        Funct3M        = f3;
        ALU_ResultM    = addr;
        WriteDataM     = wd;
        FP_WriteDataM  = fpwd;
        FP_ALU_ResultM = ~addr;
        dmem_rdata     = rdata;
        dmem_ack       = ack;
        RdM            = rd;
    endtask

    task automatic set_idle();
        set_in(6'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    endtask

    initial begin
        int n;
        vecs[0]  = '{6'b111010, 2'b00, 3'b010, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 1'b1,
                     1'b1, 32'h0, 4'h0, 2'b11, 32'hDEADBEEF, 32'h0, 1'b0};
        vecs[1]  = '{6'b111010, 2'b00, 3'b000, 32'h103, 32'h0, 32'h0, 32'h80112233, 1'b1,
                     1'b1, 32'h0, 4'h0, 2'b11, 32'hFFFFFF80, 32'h0, 1'b0};
        vecs[2]  = '{6'b111010, 2'b00, 3'b100, 32'h103, 32'h0, 32'h0, 32'h80112233, 1'b1,
                     1'b1, 32'h0, 4'h0, 2'b11, 32'h00000080, 32'h0, 1'b0};
        vecs[3]  = '{6'b111010, 2'b00, 3'b001, 32'h102, 32'h0, 32'h0, 32'h80112233, 1'b1,
                     1'b1, 32'h0, 4'h0, 2'b11, 32'hFFFF8011, 32'h0, 1'b0};
        vecs[4]  = '{6'b111010, 2'b00, 3'b101, 32'h100, 32'h0, 32'h0, 32'h80112233, 1'b1,
                     1'b1, 32'h0, 4'h0, 2'b11, 32'h00002233, 32'h0, 1'b0};
        vecs[5]  = '{6'b100001, 2'b00, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 32'h0, 1'b1,
                     1'b1, 32'hABCDABCD, 4'b1100, 2'b00, 32'h0, 32'h0, 1'b0};
        vecs[6]  = '{6'b100001, 2'b00, 3'b000, 32'h201, 32'h123456A5, 32'h0, 32'h0, 1'b1,
                     1'b1, 32'hA5A5A5A5, 4'b0010, 2'b00, 32'h0, 32'h0, 1'b0};
        vecs[7]  = '{6'b100001, 2'b00, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 32'h0, 1'b1,
                     1'b1, 32'hCAFEF00D, 4'b1111, 2'b00, 32'h0, 32'h0, 1'b0};
        vecs[8]  = '{6'b100101, 2'b00, 3'b010, 32'h208, 32'h11111111, 32'h3F800000, 32'h0, 1'b1,
                     1'b1, 32'h3F800000, 4'b1111, 2'b00, 32'h0, 32'h0, 1'b0};
        vecs[9]  = '{6'b111110, 2'b00, 3'b010, 32'h20C, 32'h0, 32'h0, 32'h40490FDB, 1'b1,
                     1'b1, 32'h0, 4'h0, 2'b11, 32'h40490FDB, 32'h40490FDB, 1'b0};
        vecs[10] = '{6'b111010, 2'b00, 3'b010, 32'h102, 32'h0, 32'h0, 32'h0, 1'b0,
                     1'b0, 32'h0, 4'h0, 2'b01, 32'h0, 32'h0, 1'b1};
        vecs[11] = '{6'b111010, 2'b00, 3'b001, 32'h101, 32'h0, 32'h0, 32'h0, 1'b0,
                     1'b0, 32'h0, 4'h0, 2'b01, 32'h0, 32'h0, 1'b1};
        vecs[12] = '{6'b110000, 2'b00, 3'b000, 32'h55AA, 32'h0, 32'h0, 32'h0, 1'b0,
                     1'b0, 32'h0, 4'h0, 2'b10, 32'h0, 32'h0, 1'b0};
        vecs[13] = '{6'b011010, 2'b00, 3'b010, 32'h100, 32'h0, 32'h0, 32'h12345678, 1'b0,
                     1'b0, 32'h0, 4'h0, 2'b01, 32'h12345678, 32'h0, 1'b0};

        // Reset state, with a load presented so the request must be suppressed
        rst_n = 1'b0;
        set_in(6'b111010, 2'b00, 3'b010, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0, 5'd1);
        #2;
        chk("rst dmem_req", 32'(dmem_req), 32'h0);
        chk("rst StallM", 32'(StallM), 32'h0);
        chk("rst ValidW", 32'(ValidW), 32'h0);
        chk("rst RegWriteW", 32'(RegWriteW), 32'h0);
        chk("rst ReadDataW", ReadDataW, 32'h0);
        chk("rst BusErrW", 32'(BusErrW), 32'h0);
        set_idle();
        step();
        step();
        rst_n = 1'b1;

        // Single-cycle vector table
        for (int i = 0; i < NV; i++) begin
            set_in(vecs[i].ctl, vecs[i].amo, vecs[i].f3, vecs[i].addr, vecs[i].wd,
                   vecs[i].fpwd, vecs[i].rdata, vecs[i].ack, 5'(i + 1));
            #1;
            chk($sformatf("v%0d dmem_req", i), 32'(dmem_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d dmem_we", i), 32'(dmem_we), 32'(vecs[i].ctl[0]));
            chk($sformatf("v%0d dmem_addr", i), dmem_addr, {vecs[i].addr[31:2], 2'b00});
            chk($sformatf("v%0d dmem_wdata", i), dmem_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d dmem_wstrb", i), 32'(dmem_wstrb), 32'(vecs[i].e_strb));
            chk($sformatf("v%0d StallM", i), 32'(StallM), 32'h0);
            step();
            chk($sformatf("v%0d ValidW", i), 32'(ValidW), 32'(vecs[i].ctl[5]));
            chk($sformatf("v%0d RegWriteW", i), 32'(RegWriteW), 32'(vecs[i].e_rwrs[1]));
            chk($sformatf("v%0d ResultSrcW", i), 32'(ResultSrcW), 32'(vecs[i].e_rwrs[0]));
            chk($sformatf("v%0d isFPUW", i), 32'(isFPUW), 32'(vecs[i].ctl[2]));
            chk($sformatf("v%0d RdW", i), 32'(RdW), 32'(i + 1));
            chk($sformatf("v%0d ALU_ResultW", i), ALU_ResultW, vecs[i].addr);
            chk($sformatf("v%0d FP_ALU_ResultW", i), FP_ALU_ResultW, ~vecs[i].addr);
            chk($sformatf("v%0d ReadDataW", i), ReadDataW, vecs[i].e_rdw);
            chk($sformatf("v%0d FP_ReadDataW", i), FP_ReadDataW, vecs[i].e_fprd);
            chk($sformatf("v%0d MisalignW", i), 32'(MisalignW), 32'(vecs[i].e_mis));
            chk($sformatf("v%0d BusErrW", i), 32'(BusErrW), 32'h0);
        end

        // Ack delayed by three cycles: three stall cycles, three bubbles, one delivery
        set_in(6'b111010, 2'b00, 3'b010, 32'h400, 32'h0, 32'h0, 32'h0BADF00D, 1'b0, 5'd7);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("dly%0d StallM", k), 32'(StallM), 32'h1);
            chk($sformatf("dly%0d dmem_req", k), 32'(dmem_req), 32'h1);
            step();
            chk($sformatf("dly%0d bubble ValidW", k), 32'(ValidW), 32'h0);
            chk($sformatf("dly%0d bubble RegWriteW", k), 32'(RegWriteW), 32'h0);
        end
        dmem_ack = 1'b1;
        #1;
        chk("dly ack StallM", 32'(StallM), 32'h0);
        step();
        chk("dly ValidW", 32'(ValidW), 32'h1);
        chk("dly RegWriteW", 32'(RegWriteW), 32'h1);
        chk("dly ReadDataW", ReadDataW, 32'h0BADF00D);
        set_idle();
        step();
        chk("dly once ValidW", 32'(ValidW), 32'h0);

        // Timeout: no ack ever
        set_in(6'b111010, 2'b00, 3'b010, 32'h500, 32'h0, 32'h0, 32'h0, 1'b0, 5'd8);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!StallM) break;
            n++;
            step();
        end
        chk("tmo stall cycles", 32'(n), 32'd16);
        step();
        chk("tmo BusErrW", 32'(BusErrW), 32'h1);
        chk("tmo RegWriteW", 32'(RegWriteW), 32'h0);
        chk("tmo ValidW", 32'(ValidW), 32'h1);
        set_idle();
        step();
        chk("tmo BusErrW clears", 32'(BusErrW), 32'h0);

        // LR.W then SC.W succeeds, second SC.W fails without a request
        set_in(6'b111010, 2'b01, 3'b010, 32'h300, 32'h0, 32'h0, 32'h77, 1'b1, 5'd9);
        step();
        chk("lr RegWriteW", 32'(RegWriteW), 32'h1);
        set_in(6'b111001, 2'b10, 3'b010, 32'h300, 32'hAAAA5555, 32'h0, 32'h0, 1'b1, 5'd9);
        #1;
        chk("sc1 dmem_req", 32'(dmem_req), 32'h1);
        chk("sc1 dmem_wdata", dmem_wdata, 32'hAAAA5555);
        step();
        chk("sc1 ALU_ResultW", ALU_ResultW, 32'h0);
        chk("sc1 ResultSrcW", 32'(ResultSrcW), 32'h0);
        chk("sc1 RegWriteW", 32'(RegWriteW), 32'h1);
        dmem_ack = 1'b0;
        #1;
        chk("sc2 dmem_req", 32'(dmem_req), 32'h0);
        chk("sc2 StallM", 32'(StallM), 32'h0);
        step();
        chk("sc2 ALU_ResultW", ALU_ResultW, 32'h1);
        chk("sc2 ResultSrcW", 32'(ResultSrcW), 32'h0);

        // Store to a different word keeps the reservation
        set_in(6'b111010, 2'b01, 3'b010, 32'h600, 32'h0, 32'h0, 32'h1, 1'b1, 5'd3);
        step();
        set_in(6'b100001, 2'b00, 3'b010, 32'h604, 32'h5, 32'h0, 32'h0, 1'b1, 5'd0);
        step();
        set_in(6'b111001, 2'b10, 3'b010, 32'h600, 32'h6, 32'h0, 32'h0, 1'b1, 5'd3);
        #1;
        chk("resv keep dmem_req", 32'(dmem_req), 32'h1);
        step();
        chk("resv keep ALU_ResultW", ALU_ResultW, 32'h0);

        // Store to the reserved word kills the reservation
        set_in(6'b111010, 2'b01, 3'b010, 32'h600, 32'h0, 32'h0, 32'h1, 1'b1, 5'd3);
        step();
        set_in(6'b100001, 2'b00, 3'b010, 32'h600, 32'h5, 32'h0, 32'h0, 1'b1, 5'd0);
        step();
        set_in(6'b111001, 2'b10, 3'b010, 32'h600, 32'h6, 32'h0, 32'h0, 1'b1, 5'd3);
        #1;
        chk("resv kill dmem_req", 32'(dmem_req), 32'h0);
        step();
        chk("resv kill ALU_ResultW", ALU_ResultW, 32'h1);

        // Reset in the middle of a waiting load; reservation must be dropped too
        set_in(6'b111010, 2'b01, 3'b010, 32'h800, 32'h0, 32'h0, 32'h1, 1'b1, 5'd4);
        step();
        set_in(6'b111010, 2'b00, 3'b010, 32'h700, 32'h0, 32'h0, 32'h0, 1'b0, 5'd5);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mid-rst dmem_req", 32'(dmem_req), 32'h0);
        chk("mid-rst StallM", 32'(StallM), 32'h0);
        chk("mid-rst dmem_we", 32'(dmem_we), 32'h0);
        set_idle();
        step();
        rst_n = 1'b1;
        set_in(6'b111001, 2'b10, 3'b010, 32'h800, 32'h6, 32'h0, 32'h0, 1'b1, 5'd4);
        #1;
        chk("post-rst sc dmem_req", 32'(dmem_req), 32'h0);
        step();
        chk("post-rst sc ALU_ResultW", ALU_ResultW, 32'h1);
        set_in(6'b111010, 2'b00, 3'b010, 32'h710, 32'h0, 32'h0, 32'h600DCAFE, 1'b1, 5'd6);
        #1;
        chk("post-rst lw StallM", 32'(StallM), 32'h0);
        step();
        chk("post-rst lw ReadDataW", ReadDataW, 32'h600DCAFE);
        chk("post-rst lw ValidW", 32'(ValidW), 32'h1);

        set_idle();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
